epp_read_responder: RTL and testbench
=====================================

Name: epp_read_responder

Overview:
- EPP peripheral-side read path: serves host address-read and data-read cycles, driving EppDB and a read-side Wait.
- Tracks the EPP address register by snooping host address-write cycles.
- Lets the host poll GraphicsCard status (busy/error) and read back the coordinate registers the EPP write block last programmed.
- Sits in top beside EPP. top ORs the two Wait contributions and builds the EppDB tristate from db_out/db_oe.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on the asynchronous strobe inputs (allowed values 2..3).
- DEVICE_ID, 8'hA5, constant returned at register address 7.
- AUTO_INC, 1, when 1 the address register increments (mod 256) after each completed data read.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- epp_astb  in  1  host address strobe, active low, asynchronous to clk
- epp_dstb  in  1  host data strobe, active low, asynchronous
- epp_wr  in  1  host direction: 0 = write, 1 = read
- epp_db_in  in  8  EppDB as seen from the pad
- epp_db_out  out  8  read data to the pad driver
- epp_db_oe  out  1  pad output enable; 1 = drive EppDB
- epp_wait_rd  out  1  read-side Wait contribution; top ORs it with the writer's Wait
- busy  in  1  GraphicsCard operation in progress
- error  in  1  GraphicsCard error flag
- x1, x2  in  9  coordinate sources
- y1, y2  in  8  coordinate sources

Behaviour:
- Reset (async, takes effect immediately, including mid-cycle):
  - epp_db_oe=0, epp_wait_rd=0, epp_db_out=0.
  - addr=0, shadows=0, state IDLE.
- Synchronization: astb, dstb and wr each pass through SYNC_STAGES flops. All decisions use the synced versions (as, ds, wrs). epp_db_in is sampled only when as is low, so it is stable by then.
- States: IDLE, ADDR_SNOOP, READ_DRIVE, READ_WAIT.
- IDLE:
  - as=0 and wrs=0 -> addr<=epp_db_in, go to ADDR_SNOOP. No Wait is driven; the writer owns that handshake.
  - as=0 and wrs=1 -> epp_db_out<=addr, epp_db_oe<=1, go to READ_DRIVE.
  - ds=0 and wrs=1 -> epp_db_out<=regmap(addr), epp_db_oe<=1, go to READ_DRIVE.
  - ds=0 and wrs=0 -> ignored; stay in IDLE, no outputs change.
  - as and ds both low -> as wins; ds is ignored for that cycle.
- ADDR_SNOOP: stay until as=1, then go to IDLE.
- READ_DRIVE: one cycle. epp_wait_rd<=1, go to READ_WAIT. Data has therefore been on the bus at least one cycle before Wait rises.
- READ_WAIT:
  - Hold epp_db_out/epp_db_oe/epp_wait_rd until the strobe that started the cycle reads 1 after sync.
  - In that same clock edge: epp_wait_rd<=0, epp_db_oe<=0, go to IDLE.
  - If the cycle was a data read and AUTO_INC=1: addr<=addr+1, with 8'hFF wrapping to 8'h00.
  - wr is sampled only at cycle start; later changes are ignored.
- Latency:
  - Synced strobe low seen at edge N -> oe and data valid after edge N+1, Wait high after edge N+2.
  - Synced strobe high at edge M -> Wait and oe low after edge M+1.
- Register map (regmap):
  - 0: {6'b0, error, busy}, sampled live at cycle start.
  - 1: x1[7:0], and latches x1[8] into shadow_x1h.
  - 2: {7'b0, shadow_x1h}.
  - 3: y1.
  - 4: x2[7:0], and latches x2[8] into shadow_x2h.
  - 5: {7'b0, shadow_x2h}.
  - 6: y2.
  - 7: DEVICE_ID.
  - 8..255: 8'h00.
- Shadows update only on data reads of address 1 or 4. They are not reset by address writes.
- epp_db_out is held, not zeroed, while oe=0.

Decomposition:
- Package epp_pkg holds:
  - State enum for the FSM.
  - Register-address constants: REG_STATUS=0, REG_X1L=1, REG_X1H=2, REG_Y1=3, REG_X2L=4, REG_X2H=5, REG_Y2=6, REG_ID=7.
  - Default DEVICE_ID.
- Sub-module epp_sync: parameterised N-stage synchronizer with reset value 1 (strobes idle high). Instantiated three times.

Test Plan:
- Reset release, no strobes -> oe=0, wait=0, db_out=00; an address read returns 00.
- Address write 8'h07, then data read -> db_out=A5. oe rises 1 cycle before wait. wait falls 1 cycle after synced dstb rises. addr becomes 08.
- x1=9'h1C3, read addr 1 -> C3. Change x1 to 9'h005, then read addr 2 -> 01 (shadow retained).
- busy=1, error=0, AUTO_INC=1: two consecutive data reads starting at addr 0 -> 01 then x1[7:0]. Address write FF, two data reads -> 00 then error/busy status (addr wrapped to 0).
- Assert reset during READ_WAIT with dstb still low -> oe and wait drop immediately (asynchronously). After reset release with dstb still low, a new read cycle starts at addr 0.
- astb and dstb low together with wr=1 -> address read; db_out=current addr. Data write cycle (ds=0, wrs=0) -> oe and wait stay 0 throughout.

Source files
------------

// File: rtl/epp_pkg.sv
// rtl/epp_pkg.sv - shared FSM state codes and register map for the EPP read responder
package epp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_ADDR_SNOOP = 2'd1;
    localparam state_t ST_READ_DRIVE = 2'd2;
    localparam state_t ST_READ_WAIT  = 2'd3;

    localparam logic [7:0] REG_STATUS = 8'd0;
    localparam logic [7:0] REG_X1L    = 8'd1;
    localparam logic [7:0] REG_X1H    = 8'd2;
    localparam logic [7:0] REG_Y1     = 8'd3;
    localparam logic [7:0] REG_X2L    = 8'd4;
    localparam logic [7:0] REG_X2H    = 8'd5;
    localparam logic [7:0] REG_Y2     = 8'd6;
    localparam logic [7:0] REG_ID     = 8'd7;

    localparam logic [7:0] DEFAULT_DEVICE_ID = 8'hA5;

endpackage

// File: rtl/epp_sync.sv
// rtl/epp_sync.sv - N-stage synchronizer, resets high so idle strobes read inactive
module epp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '1;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/epp_read_responder.sv
// rtl/epp_read_responder.sv - EPP peripheral read path: address snoop, register readback, read-side Wait
module epp_read_responder
    import epp_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVICE_ID   = DEFAULT_DEVICE_ID,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       epp_astb,
    input  logic       epp_dstb,
    input  logic       epp_wr,
    input  logic [7:0] epp_db_in,
    output logic [7:0] epp_db_out,
    output logic       epp_db_oe,
    output logic       epp_wait_rd,
    input  logic       busy,
    input  logic       error,
    input  logic [8:0] x1,
    input  logic [8:0] x2,
    input  logic [7:0] y1,
    input  logic [7:0] y2
);

    logic       as_s;
    logic       ds_s;
    logic       wrs;
    state_t     state;
    logic [7:0] addr;
    logic       shadow_x1h;
    logic       shadow_x2h;
    logic       cyc_data;
    logic [7:0] rd_data;
    logic       strobe_released;

    epp_sync #(.STAGES(SYNC_STAGES)) u_sync_astb (.clk(clk), .reset(reset), .d(epp_astb), .q(as_s));
    epp_sync #(.STAGES(SYNC_STAGES)) u_sync_dstb (.clk(clk), .reset(reset), .d(epp_dstb), .q(ds_s));
    epp_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk), .reset(reset), .d(epp_wr),   .q(wrs));

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            REG_STATUS: rd_data = {6'b0, error, busy};
            REG_X1L:    rd_data = x1[7:0];
            REG_X1H:    rd_data = {7'b0, shadow_x1h};
            REG_Y1:     rd_data = y1;
            REG_X2L:    rd_data = x2[7:0];
            REG_X2H:    rd_data = {7'b0, shadow_x2h};
            REG_Y2:     rd_data = y2;
            REG_ID:     rd_data = DEVICE_ID;
            default:    rd_data = 8'h00;
        endcase
    end

    // Release is judged on whichever strobe opened the cycle; wr is not re-sampled
    assign strobe_released = cyc_data ? ds_s : as_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            addr        <= 8'h00;
            shadow_x1h  <= 1'b0;
            shadow_x2h  <= 1'b0;
            cyc_data    <= 1'b0;
            epp_db_out  <= 8'h00;
            epp_db_oe   <= 1'b0;
            epp_wait_rd <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!as_s) begin
                        if (!wrs) begin
                            addr  <= epp_db_in;
                            state <= ST_ADDR_SNOOP;
                        end else begin
                            epp_db_out <= addr;
                            epp_db_oe  <= 1'b1;
                            cyc_data   <= 1'b0;
                            state      <= ST_READ_DRIVE;
                        end
                    end else if (!ds_s && wrs) begin
                        epp_db_out <= rd_data;
                        epp_db_oe  <= 1'b1;
                        cyc_data   <= 1'b1;
                        state      <= ST_READ_DRIVE;
                        if (addr == REG_X1L) shadow_x1h <= x1[8];
                        if (addr == REG_X2L) shadow_x2h <= x2[8];
                    end
                end
                ST_ADDR_SNOOP: begin
                    if (as_s) state <= ST_IDLE;
                end
                ST_READ_DRIVE: begin
                    epp_wait_rd <= 1'b1;
                    state       <= ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    if (strobe_released) begin
                        epp_wait_rd <= 1'b0;
                        epp_db_oe   <= 1'b0;
                        state       <= ST_IDLE;
                        if (cyc_data && AUTO_INC) addr <= addr + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_epp_read_responder.sv
// tb/tb_epp_read_responder.sv - directed self-checking bench for epp_read_responder
module tb_epp_read_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       epp_astb = 1'b1;
    logic       epp_dstb = 1'b1;
    logic       epp_wr = 1'b1;
    logic [7:0] epp_db_in = 8'h00;
    logic [7:0] epp_db_out;
    logic       epp_db_oe;
    logic       epp_wait_rd;
    logic       busy = 1'b0;
    logic       error = 1'b0;
    logic [8:0] x1 = 9'h000;
    logic [8:0] x2 = 9'h000;
    logic [7:0] y1 = 8'h00;
    logic [7:0] y2 = 8'h00;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    epp_read_responder dut (
        .clk(clk), .reset(reset),
        .epp_astb(epp_astb), .epp_dstb(epp_dstb), .epp_wr(epp_wr),
        .epp_db_in(epp_db_in), .epp_db_out(epp_db_out),
        .epp_db_oe(epp_db_oe), .epp_wait_rd(epp_wait_rd),
        .busy(busy), .error(error),
        .x1(x1), .x2(x2), .y1(y1), .y2(y2)
    );

    // mode: 0 = address read, 1 = data read, 2 = both strobes low together
    task automatic do_read(input int mode, output logic [7:0] d, output int oe_cyc,
                           output int wait_cyc, output int rel_cyc, output bit timeout);
        bit done;
        oe_cyc = -1; wait_cyc = -1; rel_cyc = -1; timeout = 1'b0; d = 8'hxx;
        @(negedge clk);
        epp_wr = 1'b1;
        if (mode != 1) epp_astb = 1'b0;
        if (mode != 0) epp_dstb = 1'b0;
        done = 1'b0;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(negedge clk);
            if (oe_cyc < 0 && epp_db_oe) oe_cyc = i;
            if (epp_wait_rd) begin
                wait_cyc = i;
                done = 1'b1;
            end
        end
        if (!done) timeout = 1'b1;
        d = epp_db_out;
        epp_astb = 1'b1;
        epp_dstb = 1'b1;
        done = 1'b0;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(negedge clk);
            if (!epp_wait_rd && !epp_db_oe) begin
                rel_cyc = i;
                done = 1'b1;
            end
        end
        if (!done) timeout = 1'b1;
        @(negedge clk);
    endtask

    task automatic addr_write(input logic [7:0] a);
        @(negedge clk);
        epp_wr = 1'b0;
        epp_db_in = a;
        epp_astb = 1'b0;
        repeat (6) @(negedge clk);
        epp_astb = 1'b1;
        repeat (5) @(negedge clk);
        epp_wr = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0] d; int o, w, r; bit to;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (epp_db_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", epp_db_oe); end
        n_checks++;
        if (epp_wait_rd !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got %b want 0", epp_wait_rd); end
        n_checks++;
        if (epp_db_out !== 8'h00) begin n_fail++; $display("FAIL reset_db: got %h want 00", epp_db_out); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        do_read(0, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h00) begin n_fail++; $display("FAIL reset_addr_read: got %h timeout=%0d want 00", d, to); end
    endtask

    task automatic test_id_read;
        logic [7:0] d; int o, w, r; bit to;
        addr_write(8'h07);
        do_read(1, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'hA5) begin n_fail++; $display("FAIL id_read: got %h timeout=%0d want a5", d, to); end
        n_checks++;
        if (o !== 3 || w !== 4) begin n_fail++; $display("FAIL id_oe_wait_timing: oe at %0d wait at %0d want 3 and 4", o, w); end
        n_checks++;
        if (r !== 3) begin n_fail++; $display("FAIL id_release: got %0d cycles want 3", r); end
        n_checks++;
        if (epp_db_out !== 8'hA5) begin n_fail++; $display("FAIL db_held: got %h want a5", epp_db_out); end
        do_read(0, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h08) begin n_fail++; $display("FAIL id_autoinc: got %h timeout=%0d want 08", d, to); end
    endtask

    task automatic test_shadow;
        logic [7:0] d; int o, w, r; bit to;
        x1 = 9'h1C3;
        addr_write(8'h01);
        do_read(1, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'hC3) begin n_fail++; $display("FAIL shadow_x1l: got %h timeout=%0d want c3", d, to); end
        x1 = 9'h005;
        do_read(1, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h01) begin n_fail++; $display("FAIL shadow_x1h: got %h timeout=%0d want 01", d, to); end
    endtask

    task automatic test_auto_inc;
        logic [7:0] d; int o, w, r; bit to;
        busy = 1'b1; error = 1'b0;
        addr_write(8'h00);
        do_read(1, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h01) begin n_fail++; $display("FAIL autoinc_status: got %h timeout=%0d want 01", d, to); end
        do_read(1, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h05) begin n_fail++; $display("FAIL autoinc_x1l: got %h timeout=%0d want 05", d, to); end
        addr_write(8'hFF);
        do_read(1, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h00) begin n_fail++; $display("FAIL wrap_ff: got %h timeout=%0d want 00", d, to); end
        do_read(1, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h01) begin n_fail++; $display("FAIL wrap_status: got %h timeout=%0d want 01", d, to); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d; int o, w, r; bit to; bit seen;
        busy = 1'b0; error = 1'b1;
        addr_write(8'h03);
        @(negedge clk);
        epp_wr = 1'b1; epp_dstb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (epp_wait_rd) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL mid_wait_rise: wait never rose want 1"); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (epp_db_oe !== 1'b0 || epp_wait_rd !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_reset: oe=%b wait=%b want 0 0", epp_db_oe, epp_wait_rd);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (epp_wait_rd) seen = 1'b1;
        end
        n_checks++;
        if (!seen || epp_db_out !== 8'h02) begin
            n_fail++; $display("FAIL mid_restart: got %h wait_seen=%0d want 02", epp_db_out, seen);
        end
        epp_dstb = 1'b1;
        repeat (5) @(negedge clk);
        do_read(0, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h01) begin n_fail++; $display("FAIL mid_addr_after: got %h timeout=%0d want 01", d, to); end
    endtask

    task automatic test_simul_strobes;
        logic [7:0] d; int o, w, r; bit to; bit bad;
        addr_write(8'h5A);
        do_read(2, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h5A) begin n_fail++; $display("FAIL both_strobes: got %h timeout=%0d want 5a", d, to); end
        @(negedge clk);
        epp_wr = 1'b0; epp_db_in = 8'h33; epp_dstb = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (epp_db_oe || epp_wait_rd) bad = 1'b1;
        end
        epp_dstb = 1'b1;
        repeat (5) @(negedge clk);
        epp_wr = 1'b1;
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL data_write_quiet: oe/wait asserted want 0"); end
        do_read(0, d, o, w, r, to);
        n_checks++;
        if (to || d !== 8'h5A) begin n_fail++; $display("FAIL addr_kept: got %h timeout=%0d want 5a", d, to); end
    endtask

    initial begin
        test_reset;
        test_id_read;
        test_shadow;
        test_auto_inc;
        test_reset_mid;
        test_simul_strobes;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
